switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Central route-reservation arbiter for one mesh router. It takes route reservation requests from the N port control logic instances and decides which input port owns each of the N output ports.
- It returns a per-port reservation status to each requester, and releases an output when its owner asserts relieve.
- It drives the crossbar select lines and owns the per-output round-robin fairness state.

Parameters:
- N, 4, number of router ports (inputs = outputs = N); port index 0 North, 1 South, 2 West, 3 East.
- REQUEST_WIDTH, 2, width of one requested-output field; 2^REQUEST_WIDTH >= N is required.
- SEL_WIDTH, $clog2(N), width of one crossbar select field (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset.
- routeReserveRequestValid  input  N  bit i: input i requests an output.
- routeReserveRequest  input  N*REQUEST_WIDTH  field i (bits [i*REQUEST_WIDTH +: REQUEST_WIDTH]): requested output index for input i.
- routeRelieve  input  N  bit i: input i releases the output it holds (one-cycle pulse).
- routeReserveStatus  output  N  bit i: level, high while input i holds a reservation.
- outputBusy  output  N  bit o: output o is reserved.
- outputSelect  output  N*SEL_WIDTH  field o: index of the input owning output o; valid only when outputBusy[o]=1.

Behaviour:
- Reset (rst=0 at a rising edge):
  - routeReserveStatus, outputBusy and outputSelect are all 0.
  - All round-robin pointers are 0.
  - Reset mid-reservation drops every reservation immediately; no relieve is needed.
- State per output o:
  - busy[o], owner[o] (SEL_WIDTH bits), pointer rr[o] (SEL_WIDTH bits).
  - State per input i: held[i] = routeReserveStatus[i], registered.
- Eligibility: input i is a candidate for output o in cycle t only if all of these hold:
  - routeReserveRequestValid[i]=1;
  - requested field i == o;
  - held[i]=0 at the start of t;
  - requested index < N.
- Out-of-range requests (index >= N) are ignored forever; no grant and no error output.
- A request from an input already holding a reservation is ignored.
- Grant: if busy[o]=0 at the start of t and at least one candidate exists:
  - Winner = first candidate scanning rr[o], rr[o]+1, ... modulo N.
  - At the edge ending t: busy[o]<=1, owner[o]<=winner, held[winner]<=1, rr[o]<=(winner+1) mod N.
- Latency: a request is visible in cycle t; routeReserveStatus rises at t+1 (one cycle) if the output is free and the request wins.
  - A losing requester must hold valid and its request stable until its status is 1. The allocator keeps no request memory.
- Independent outputs grant in parallel in the same cycle. Each input can win at most one output per cycle, which is guaranteed because an input names one output.
- Relieve: routeRelieve[i]=1 with held[i]=1, owner of output o = i:
  - At the edge: busy[o]<=0, held[i]<=0.
  - Status falls one cycle after the pulse.
  - Relieve with held[i]=0 is ignored.
- No bypass: in the cycle a relieve arrives, output o is still busy. Any new request for o (from another input, or from the same input in the same cycle) is granted at the earliest one cycle after the free, i.e. status rises two cycles after the relieve pulse.
- Holding relieve high for several cycles is equivalent to a single pulse.
- rr[o] changes only on a grant of output o.
- outputSelect / outputBusy are registered outputs, taken directly from the state.
- Implementation: combinational per-output rotating-priority arbiter plus registered reservation table. No deadlock detection; upstream routing guarantees acyclic requests.

Test Plan:
- Reset: rst=0 for 2 cycles with random requests -> status=0000, busy=0000, select=0 throughout; rst=1 with input 0 requesting output 3 -> status[0]=1 next cycle, busy[3]=1, select field 3 = 0.
- Contention fairness (N=4): inputs 0,1,2 all request output 1 and hold; each winner relieves 3 cycles after grant -> grant order 0,1,2, then 0 again if still requesting; never two owners at once.
- Parallel grants: input 0->out 2, input 1->out 3, input 2->out 0, input 3->out 1, all in one cycle -> status=1111 next cycle, busy=1111, select fields {out0:2, out1:3, out2:0, out3:1}.
- Relieve timing: input 2 holds out 0; input 3 requests out 0; input 2 relieves at cycle t -> busy[0]=0 at t+1, status[3]=1 at t+2, select field 0 = 3.
- Illegal/redundant: with N=3 and REQUEST_WIDTH=2, request index 3 -> never granted; input holding out 1 also requests out 2 -> ignored; relieve from a non-holding input -> no state change.
- Reset mid-operation: three outputs busy, rst=0 for one cycle -> all cleared; holding requests are re-granted starting from rr=0 priority.

Source files
------------

// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - route reservation bus between port control logic and the switch allocator
interface switch_allocator_if #(
  parameter int N             = 4,
  parameter int REQUEST_WIDTH = 2
);
  localparam int SEL_WIDTH = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]               routeReserveRequestValid;
  logic [N*REQUEST_WIDTH-1:0] routeReserveRequest;
  logic [N-1:0]               routeRelieve;
  logic [N-1:0]               routeReserveStatus;
  logic [N-1:0]               outputBusy;
  logic [N*SEL_WIDTH-1:0]     outputSelect;

  modport master (
    output routeReserveRequestValid,
    output routeReserveRequest,
    output routeRelieve,
    input  routeReserveStatus,
    input  outputBusy,
    input  outputSelect
  );

  modport slave (
    input  routeReserveRequestValid,
    input  routeReserveRequest,
    input  routeRelieve,
    output routeReserveStatus,
    output outputBusy,
    output outputSelect
  );
endinterface

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output rotating-priority arbiter with registered reservation table
module switch_allocator #(
  parameter int  N             = 4,
  parameter int  REQUEST_WIDTH = 2,
  localparam int SEL_WIDTH     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  switch_allocator_if.slave   alloc
);

  logic [N-1:0]                r_busy;
  logic [N-1:0]                r_held;
  logic [N-1:0][SEL_WIDTH-1:0] r_owner;
  logic [N-1:0][SEL_WIDTH-1:0] r_rr;

  logic [N-1:0][REQUEST_WIDTH-1:0] w_req_idx;
  logic [N-1:0][N-1:0]             w_cand;
  logic [N-1:0]                    w_grant;
  logic [N-1:0][SEL_WIDTH-1:0]     w_winner;
  logic [N-1:0][SEL_WIDTH-1:0]     w_rr_next;
  logic [N-1:0]                    w_release;
  logic [N-1:0]                    w_held_set;
  logic [N-1:0]                    w_held_clr;

  genvar g;
  for (g = 0; g < N; g++) begin : g_port
    assign w_req_idx[g] = alloc.routeReserveRequest[g*REQUEST_WIDTH +: REQUEST_WIDTH];
    assign alloc.outputSelect[g*SEL_WIDTH +: SEL_WIDTH] = r_owner[g];
  end

  assign alloc.routeReserveStatus = r_held;
  assign alloc.outputBusy         = r_busy;

  // Out-of-range indices never equal any output number, so they drop out here.
  always_comb begin
    w_cand    = '0;
    w_grant   = '0;
    w_winner  = '0;
    w_rr_next = '0;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        w_cand[o][i] = alloc.routeReserveRequestValid[i] && !r_held[i] &&
                       (int'(w_req_idx[i]) == o);
      end
      if (!r_busy[o]) begin
        for (int k = 0; k < N; k++) begin
          for (int i = 0; i < N; i++) begin
            if (!w_grant[o] && w_cand[o][i] && (i == (int'(r_rr[o]) + k) % N)) begin
              w_grant[o]  = 1'b1;
              w_winner[o] = SEL_WIDTH'(i);
            end
          end
        end
      end
      w_rr_next[o] = SEL_WIDTH'((int'(w_winner[o]) + 1) % N);
    end
  end

  // A busy output is only ever owned by a holding input, so the owner's relieve frees it.
  always_comb begin
    w_release  = '0;
    w_held_set = '0;
    w_held_clr = alloc.routeRelieve & r_held;
    for (int o = 0; o < N; o++) begin
      for (int i = 0; i < N; i++) begin
        if (r_busy[o] && (int'(r_owner[o]) == i) && alloc.routeRelieve[i]) begin
          w_release[o] = 1'b1;
        end
        if (w_grant[o] && (int'(w_winner[o]) == i)) begin
          w_held_set[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy  <= '0;
      r_held  <= '0;
      r_owner <= '0;
      r_rr    <= '0;
    end else begin
      for (int o = 0; o < N; o++) begin
        if (w_grant[o]) begin
          r_busy[o]  <= 1'b1;
          r_owner[o] <= w_winner[o];
          r_rr[o]    <= w_rr_next[o];
        end else if (w_release[o]) begin
          r_busy[o]  <= 1'b0;
        end
      end
      r_held <= (r_held & ~w_held_clr) | w_held_set;
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - directed vector bench for switch_allocator
module tb_switch_allocator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  switch_allocator_if #(.N(4), .REQUEST_WIDTH(2)) if4 ();
  switch_allocator_if #(.N(3), .REQUEST_WIDTH(2)) if3 ();

  switch_allocator #(.N(4), .REQUEST_WIDTH(2)) dut4 (.clk(clk), .rst(rst), .alloc(if4));
  switch_allocator #(.N(3), .REQUEST_WIDTH(2)) dut3 (.clk(clk), .rst(rst), .alloc(if3));

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic [7:0] req;
    logic [3:0] relieve;
    logic [3:0] exp_status;
    logic [3:0] exp_busy;
    logic [7:0] exp_sel;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic r, input logic [3:0] v, input logic [7:0] q, input logic [3:0] rl,
                     input logic [3:0] st, input logic [3:0] b, input logic [7:0] s);
    vec_t x;
    x.rst = r; x.valid = v; x.req = q; x.relieve = rl;
    x.exp_status = st; x.exp_busy = b; x.exp_sel = s;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sel_mask(input logic [3:0] busy, input logic full);
    logic [7:0] m;
    m = '0;
    for (int o = 0; o < 4; o++) if (full || busy[o]) m[2*o +: 2] = 2'b11;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [2:0] v, input logic [5:0] q, input logic [2:0] rl);
    if3.routeReserveRequestValid = v;
    if3.routeReserveRequest      = q;
    if3.routeRelieve             = rl;
  endtask

  task automatic check3(input string name, input logic [2:0] st, input logic [2:0] b);
    check({name, " status3"}, 32'(if3.routeReserveStatus), 32'(st));
    check({name, " busy3"},   32'(if3.outputBusy),         32'(b));
  endtask

  initial begin
    logic [7:0] m;
    rst = 1'b0;
    if4.routeReserveRequestValid = '0; if4.routeReserveRequest = '0; if4.routeRelieve = '0;
    drive3(3'b000, 6'h00, 3'b000);

    // reset with activity on the inputs, then input 0 takes output 3
    add(0, 4'b1111, 8'h1B, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    add(0, 4'b1010, 8'hE4, 4'b0101, 4'b0000, 4'b0000, 8'h00);
    add(1, 4'b0001, 8'h03, 4'b0000, 4'b0001, 4'b1000, 8'h00);
    add(1, 4'b0001, 8'h03, 4'b0000, 4'b0001, 4'b1000, 8'h00);
    add(1, 4'b0000, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00);
    // four parallel grants, then release all
    add(1, 4'b1111, 8'h4E, 4'b0000, 4'b1111, 4'b1111, 8'h4E);
    add(1, 4'b0000, 8'h00, 4'b1111, 4'b0000, 4'b0000, 8'h00);
    // relieve timing: 2 holds out0, 3 waits, freed then granted one cycle later
    add(1, 4'b0100, 8'h00, 4'b0000, 4'b0100, 4'b0001, 8'h02);
    add(1, 4'b1000, 8'h00, 4'b0000, 4'b0100, 4'b0001, 8'h02);
    add(1, 4'b1000, 8'h00, 4'b0100, 4'b0000, 4'b0000, 8'h00);
    add(1, 4'b1000, 8'h00, 4'b0000, 4'b1000, 4'b0001, 8'h03);
    add(1, 4'b0000, 8'h00, 4'b1000, 4'b0000, 4'b0000, 8'h00);
    // three outputs busy, mid-operation reset, rr back to 0
    add(1, 4'b0111, 8'h39, 4'b0000, 4'b0111, 4'b1110, 8'h90);
    add(0, 4'b0111, 8'h39, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    // contention on out1 from 0,1,2 with round-robin rotation
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0001, 4'b0010, 8'h00);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0001, 4'b0010, 8'h00);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0001, 4'b0010, 8'h00);
    add(1, 4'b0111, 8'h15, 4'b0001, 4'b0000, 4'b0000, 8'h00);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0010, 4'b0010, 8'h04);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0010, 4'b0010, 8'h04);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0010, 4'b0010, 8'h04);
    add(1, 4'b0111, 8'h15, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0100, 4'b0010, 8'h08);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0100, 4'b0010, 8'h08);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0100, 4'b0010, 8'h08);
    add(1, 4'b0111, 8'h15, 4'b0100, 4'b0000, 4'b0000, 8'h00);
    add(1, 4'b0111, 8'h15, 4'b0000, 4'b0001, 4'b0010, 8'h00);
    add(1, 4'b0000, 8'h00, 4'b0001, 4'b0000, 4'b0000, 8'h00);
    add(1, 4'b0000, 8'h00, 4'b0110, 4'b0000, 4'b0000, 8'h00);

    for (int r = 0; r < vecs.size(); r++) begin
      rst = vecs[r].rst;
      if4.routeReserveRequestValid = vecs[r].valid;
      if4.routeReserveRequest      = vecs[r].req;
      if4.routeRelieve             = vecs[r].relieve;
      tick();
      m = sel_mask(vecs[r].exp_busy, !vecs[r].rst);
      check($sformatf("row%0d status", r), 32'(if4.routeReserveStatus), 32'(vecs[r].exp_status));
      check($sformatf("row%0d busy", r),   32'(if4.outputBusy),         32'(vecs[r].exp_busy));
      check($sformatf("row%0d select", r), 32'(if4.outputSelect & m),   32'(vecs[r].exp_sel));
    end

    // N=3: out-of-range index, request while holding, relieve from non-holder
    rst = 1'b0;
    drive3(3'b111, 6'h3F, 3'b000);
    tick(); check3("n3 reset a", 3'b000, 3'b000);
    tick(); check3("n3 reset b", 3'b000, 3'b000);
    rst = 1'b1;
    drive3(3'b011, 6'b00_01_11, 3'b000);
    tick(); check3("n3 grant", 3'b010, 3'b010);
    check("n3 select1", 32'(if3.outputSelect[3:2]), 32'd1);
    for (int c = 0; c < 3; c++) begin
      tick(); check3($sformatf("n3 oor hold%0d", c), 3'b010, 3'b010);
    end
    drive3(3'b010, 6'b00_10_00, 3'b000);
    tick(); check3("n3 held req", 3'b010, 3'b010);
    drive3(3'b000, 6'h00, 3'b100);
    tick(); check3("n3 bad relieve", 3'b010, 3'b010);
    check("n3 select1 kept", 32'(if3.outputSelect[3:2]), 32'd1);
    drive3(3'b000, 6'h00, 3'b010);
    tick(); check3("n3 relieve a", 3'b000, 3'b000);
    tick(); check3("n3 relieve b", 3'b000, 3'b000);
    drive3(3'b000, 6'h00, 3'b000);
    tick(); check3("n3 idle", 3'b000, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
